// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard/stall sequencer: FSM state encoding and the
// bundle of pipeline write/flush controls it drives.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MD_DRAIN = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_hold;
    logic md_go;
  } hz_ctrl_t;

  // Free-running pipe vs. the "everything squashed" state held during reset.
  localparam hz_ctrl_t CTRL_DEFAULT = hz_ctrl_t'(6'b110000);
  localparam hz_ctrl_t CTRL_RESET   = hz_ctrl_t'(6'b001100);

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: a load in ID/EX whose destination is read by the
// instruction currently in IF/ID. x0 never creates a dependency.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             lu
);

  assign lu = id_ex_memread && (id_ex_rd != '0) &&
              ((use_rs1 && (if_id_rs1 == id_ex_rd)) ||
               (use_rs2 && (if_id_rs2 == id_ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage core: load-use bubbles, taken-branch
// flushes and the mul/div freeze with watchdog, plus a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYC = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             md_go,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W = (MD_MAX_CYC > 2) ? $clog2(MD_MAX_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYC - 1);

  hz_state_t       state;
  logic [WD_W-1:0] wd_cnt;
  logic            lu;
  hz_ctrl_t        ctrl;

  load_use_detect u_load_use_detect (
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .use_rs1       (use_rs1),
    .use_rs2       (use_rs2),
    .lu            (lu)
  );

  // Mealy controls; a taken branch wins in RUN because anything behind it is wrong-path.
  always_comb begin
    ctrl = CTRL_DEFAULT;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
          end else if (md_start) begin
            ctrl.md_go       = 1'b1;
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_write = 1'b0;
            ctrl.ex_hold     = 1'b1;
          end else if (lu) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.ex_hold     = 1'b1;
        end
        MD_DRAIN: begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end
        default: ctrl = CTRL_DEFAULT;
      endcase
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_hold      = ctrl.ex_hold;
  assign md_go        = ctrl.md_go;

  // md_done on the last watchdog cycle takes priority over expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wd_cnt       <= '0;
      stall_cycles <= '0;
      md_err       <= 1'b0;
    end else begin
      if (!ctrl.pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      case (state)
        RUN: begin
          if (!branch_taken && md_start) begin
            wd_cnt <= '0;
            state  <= MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state <= MD_DRAIN;
          end else if (wd_cnt == WD_LAST) begin
            md_err <= 1'b1;
            state  <= MD_DRAIN;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        MD_DRAIN: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;

  localparam int MD_MAX_CYC = 8;
  localparam int CNT_W      = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, md_go}
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_LU    = 6'b000100;
  localparam logic [5:0] C_BR    = 6'b111100;
  localparam logic [5:0] C_GO    = 6'b000011;
  localparam logic [5:0] C_WAIT  = 6'b000010;
  localparam logic [5:0] C_DRAIN = 6'b000100;
  localparam logic [5:0] C_RST   = 6'b001100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_ex_memread = 1'b0;
  logic [4:0]       id_ex_rd = '0;
  logic [4:0]       if_id_rs1 = '0;
  logic [4:0]       if_id_rs2 = '0;
  logic             use_rs1 = 1'b0;
  logic             use_rs2 = 1'b0;
  logic             branch_taken = 1'b0;
  logic             md_start = 1'b0;
  logic             md_done = 1'b0;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, md_go, md_err;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct {
    string      name;
    logic [5:0] ctrl;
    logic       err;
    int         stall;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl #(.MD_MAX_CYC(MD_MAX_CYC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_ex_memread (id_ex_memread),
    .id_ex_rd      (id_ex_rd),
    .if_id_rs1     (if_id_rs1),
    .if_id_rs2     (if_id_rs2),
    .use_rs1       (use_rs1),
    .use_rs2       (use_rs2),
    .branch_taken  (branch_taken),
    .md_start      (md_start),
    .md_done       (md_done),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_hold       (ex_hold),
    .md_go         (md_go),
    .md_err        (md_err),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input string name, input logic [5:0] eCtrl, input logic eErr, input int eStall);
    exp_t e;
    e.name  = name;
    e.ctrl  = eCtrl;
    e.err   = eErr;
    e.stall = eStall;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input logic memread, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic br, input logic st, input logic dn,
                               input logic [5:0] eCtrl, input logic eErr, input int eStall);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    id_ex_memread = memread;
    id_ex_rd      = rd;
    if_id_rs1     = rs1;
    if_id_rs2     = rs2;
    use_rs1       = u1;
    use_rs2       = u2;
    branch_taken  = br;
    md_start      = st;
    md_done       = dn;
    pushExp(name, eCtrl, eErr, eStall);
  endtask

  task automatic idleVec(input string name, input logic [5:0] eCtrl, input logic eErr, input int eStall);
    applyStimulus(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eCtrl, eErr, eStall);
  endtask

  task automatic mdVec(input string name, input logic dn, input logic [5:0] eCtrl, input logic eErr, input int eStall);
    applyStimulus(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, dn, eCtrl, eErr, eStall);
  endtask

  // Reset asserted mid-cycle so its asynchronous effect is visible before the next edge.
  task automatic resetCycle(input string name);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    id_ex_memread = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    branch_taken  = 1'b0;
    md_start      = 1'b0;
    md_done       = 1'b0;
    pushExp(name, C_RST, 1'b0, 0);
  endtask

  task automatic checkOutput(input string name, input string field, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h at %0t", name, field, actual, expected, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput(e.name, "ctrl",
                    int'({pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, md_go}),
                    int'(e.ctrl));
        checkOutput(e.name, "md_err", int'(md_err), int'(e.err));
        checkOutput(e.name, "stall", int'(stall_cycles), e.stall);
      end
    end
  end

  initial begin : driver
    resetCycle("reset0");
    idleVec("idle", C_RUN, 1'b0, 0);

    applyStimulus("lu_rs1",   1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, 0);
    applyStimulus("lu_rd0",   1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0, 1);
    applyStimulus("lu_nouse", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0, 1);
    applyStimulus("lu_rs2",   1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, 1);
    applyStimulus("no_load",  1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 1'b0, 2);

    applyStimulus("br_prio",  1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_BR,  1'b0, 2);
    idleVec("br_after", C_RUN, 1'b0, 2);

    // md_done alongside md_go must be ignored; the real done arrives 4 cycles later.
    mdVec("md_go", 1'b1, C_GO, 1'b0, 2);
    mdVec("md_w1", 1'b0, C_WAIT, 1'b0, 3);
    applyStimulus("md_w2_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_WAIT, 1'b0, 4);
    applyStimulus("md_w3_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_WAIT, 1'b0, 5);
    mdVec("md_w4_done", 1'b1, C_WAIT, 1'b0, 6);
    mdVec("md_drain", 1'b0, C_DRAIN, 1'b0, 7);
    applyStimulus("md_after", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN, 1'b0, 8);

    resetCycle("reset_wd");
    mdVec("wd_go", 1'b0, C_GO, 1'b0, 0);
    for (int i = 1; i <= 8; i++)
      mdVec($sformatf("wd_wait%0d", i), 1'b0, C_WAIT, 1'b0, i);
    idleVec("wd_drain", C_DRAIN, 1'b1, 9);
    idleVec("wd_run", C_RUN, 1'b1, 10);
    applyStimulus("wd_sticky_lu", 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 1'b1, 10);
    idleVec("wd_sticky", C_RUN, 1'b1, 11);

    resetCycle("reset_wd_done");
    mdVec("wdd_go", 1'b0, C_GO, 1'b0, 0);
    for (int i = 1; i <= 8; i++)
      mdVec($sformatf("wdd_wait%0d", i), (i == 8), C_WAIT, 1'b0, i);
    idleVec("wdd_drain", C_DRAIN, 1'b0, 9);
    idleVec("wdd_run", C_RUN, 1'b0, 10);

    mdVec("rst_go", 1'b0, C_GO, 1'b0, 10);
    mdVec("rst_wait", 1'b0, C_WAIT, 1'b0, 11);
    resetCycle("rst_mid_wait");
    applyStimulus("post_rst_lu", 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 0);
    idleVec("post_rst_idle", C_RUN, 1'b0, 1);

    for (int j = 0; j < 20; j++)
      applyStimulus($sformatf("sat%0d", j), 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    C_LU, 1'b0, ((1 + j) > 15) ? 15 : (1 + j));
    idleVec("sat_hold", C_RUN, 1'b0, 15);

    begin
      int budget = 10;
      while (sbq.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1;
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("[TB] FAIL drain_queue actual=%0d expected=0 pending entries", sbq.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : timeout
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
